// File: rtl/cvt_share_ctrl.sv
// Round-robin controller sharing one float<->int conversion datapath among NUM_REQ requesters.
// One transaction in flight: grant in IDLE, settle LATENCY cycles in WAIT, hold the result in RESP.

module Floating_Point_to_Integer (
  input  logic [31:0] a,
  output logic [31:0] z
);
  logic [7:0]  e;
  logic [31:0] mag;

  // Truncates toward zero; |x| >= 2^31, Inf and NaN all give 0x80000000.
  always_comb begin
    e   = a[30:23];
    mag = {1'b1, a[22:0], 8'b0} >> (8'd158 - e);
    if (e < 8'd127)       z = '0;
    else if (e >= 8'd158) z = 32'h8000_0000;
    else                  z = a[31] ? -mag : mag;
  end
endmodule

module Integer_to_Floating_Point (
  input  logic [31:0] a,
  output logic [31:0] z
);
  logic [31:0] mag;
  logic [31:0] norm;
  logic [4:0]  lz;
  logic [30:0] base;
  logic        rnd;

  function automatic logic [4:0] clz(input logic [31:0] v);
    clz = '0;
    for (int i = 0; i < 32; i++)
      if (v[i]) clz = 5'(31 - i);
  endfunction

  // Signed input, round to nearest even; a mantissa carry ripples into the exponent.
  always_comb begin
    mag  = a[31] ? -a : a;
    lz   = clz(mag);
    norm = mag << lz;
    base = {8'd158 - {3'b0, lz}, norm[30:8]};
    rnd  = norm[7] & ((|norm[6:0]) | norm[8]);
    z    = (a == 32'd0) ? 32'd0 : {a[31], base + 31'(rnd)};
  end
endmodule

module cvt_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_op,
  input  logic [32*NUM_REQ-1:0]      req_data,
  output logic [NUM_REQ-1:0]         resp_valid,
  input  logic [NUM_REQ-1:0]         resp_ready,
  output logic [31:0]                resp_data,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [15:0]                done_count
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int SW    = ID_W + 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, id_r, grant;
  logic              found, accept, resp_hs;
  logic              op_r, sel_op;
  logic [31:0]       data_r, sel_data;
  logic [CNT_W-1:0]  cnt;
  logic [31:0]       f2i_out, i2f_out, conv_out;

  // Cyclic scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    logic [SW-1:0]   sum;
    logic [ID_W-1:0] idx;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + SW'(k);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      idx = sum[ID_W-1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    sel_op   = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (ID_W'(i) == grant) begin
        sel_op   = req_op[i];
        sel_data = req_data[32*i +: 32];
      end
  end

  assign accept     = (state == IDLE) && found;
  assign resp_hs    = (state == RESP) && resp_ready[id_r];
  // Gate with rst_n so no grant is visible while reset is held.
  assign req_ready  = (accept && rst_n) ? (NUM_REQ'(1) << grant) : '0;
  assign resp_valid = (state == RESP) ? (NUM_REQ'(1) << id_r) : '0;
  assign busy       = (state != IDLE);
  assign grant_id   = id_r;

  Floating_Point_to_Integer u_f2i (.a(data_r), .z(f2i_out));
  Integer_to_Floating_Point u_i2f (.a(data_r), .z(i2f_out));
  assign conv_out = op_r ? i2f_out : f2i_out;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (resp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Control registers and the result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      id_r       <= '0;
      cnt        <= '0;
      done_count <= '0;
      resp_data  <= '0;
    end else begin
      if (accept) begin
        id_r   <= grant;
        rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
        cnt    <= CNT_W'(LATENCY - 1);
      end
      if (state == WAIT) begin
        if (cnt != '0) cnt <= cnt - CNT_W'(1);
        else           resp_data <= conv_out;
      end
      if (resp_hs) done_count <= done_count + 16'd1;
    end
  end

  // Operand register, loaded only on accept
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r   <= sel_op;
      data_r <= sel_data;
    end
  end
endmodule

// File: doc/cvt_share_ctrl.md
# cvt_share_ctrl

Round-robin controller that shares one float/integer conversion datapath among `NUM_REQ` requesters. It instantiates one `Floating_Point_to_Integer` and one `Integer_to_Floating_Point` converter behind a single operand register. It runs one transaction at a time and routes each result back to its originator with a valid/ready handshake. It sits between the SIMT lane issue logic and the arithmetic converters.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be ≥2.
- `LATENCY`, default 2: converter settle/pipeline cycles before result capture; must be ≥1.
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NUM_REQ  request pending, one bit per requester.
- `req_ready`  out  NUM_REQ  grant/accept; at most one bit high.
- `req_op`  in  NUM_REQ  per requester: 0 = float→int (F2I), 1 = int→float (I2F).
- `req_data`  in  32*NUM_REQ  operands; requester i uses slice [32*i+31:32*i].
- `resp_valid`  out  NUM_REQ  result available for requester i; at most one bit high.
- `resp_ready`  in  NUM_REQ  requester i accepts its result.
- `resp_data`  out  32  result, shared by all requesters; meaningful only while a `resp_valid` bit is high.
- `busy`  out  1  high whenever state ≠ IDLE.
- `grant_id`  out  $clog2(NUM_REQ)  id of the current or most recent transaction.
- `done_count`  out  16  completed transactions; wraps 0xFFFF→0.

## Operation
- **States:** IDLE, WAIT, RESP.
- **IDLE, grant selection:**
  - Grant g is the first i with `req_valid[i]`=1, scanning cyclically from `rr_ptr`.
  - `req_ready[g]`=1 combinationally in the same cycle.
  - No valid request: all `req_ready` stay 0.
- **IDLE, on the accept edge:**
  - Latch `op_r`, `data_r` and `id_r`=g.
  - Set `rr_ptr` to (g+1) mod NUM_REQ.
  - Set `cnt` to LATENCY-1 and go to WAIT.
- **Converters:** both are driven from `data_r`; `op_r` selects which output is used.
  - I2F result is the I2F converter output.
  - F2I result is the F2I converter output, passed bit-exact with no post-processing.
- **WAIT:**
  - `cnt`≠0: decrement `cnt`.
  - `cnt`=0: capture the selected converter output into `resp_data` and go to RESP.
- **RESP:**
  - `resp_valid[id_r]`=1; `resp_data` is held stable.
  - On the edge where `resp_ready[id_r]`=1: increment `done_count` and go to IDLE.
  - `resp_ready` bits of other requesters are ignored.
- **Requests in WAIT/RESP:** all `req_ready` are 0; pending requests wait. A grant is never issued in the same cycle as a response handshake.
- **Requester obligations:** hold `req_valid`, `req_op` and `req_data` stable until `req_ready`. Withdrawing valid before grant is illegal.
- **`grant_id`:** equals `id_r`.

## Timing
- **Reset values** (immediate on `rst_n` low, independent of `clk`):
  - state=IDLE, `rr_ptr`=0, `id_r`=0.
  - `req_ready`=0, `resp_valid`=0, `resp_data`=0, `busy`=0, `grant_id`=0, `done_count`=0.
- **Reset mid-transaction:** the in-flight transaction is discarded and no response is produced.
- **Latency:** with the accept at edge E0, `resp_valid` rises after edge E0+LATENCY.
- **Throughput:** minimum LATENCY+2 cycles per transaction (1 IDLE + LATENCY WAIT + ≥1 RESP).
- **Response backpressure:** RESP holds indefinitely; `resp_data` and `resp_valid` stay unchanged until the handshake.
- **Simultaneous requests:** lowest index at or after `rr_ptr` wins.
- **Pointer wrap:** NUM_REQ-1 → 0.
- **Starvation bound:** any continuously valid requester is granted within NUM_REQ transactions.

## Test plan
1. **Reset:** assert `rst_n`=0 mid-clock with random inputs → every output reads 0 immediately, and `busy`=0 after release.
2. **Single I2F, LATENCY=2:** req0 with op=1, data=10 → `req_ready[0]` high for exactly one cycle; `resp_valid[0]` rises 2 edges later with `resp_data`=0x41200000. Hold `resp_ready`=0 for 5 cycles → output stays constant. Then `done_count`=1.
3. **All four requesters at once, I2F:** data 20, 0, 0xFFFFFFFF, 0x80 → grants in order 0,1,2,3; results 0x41A00000, 0x00000000, 0xBF800000, 0x43000000; `done_count`=4.
4. **Round-robin:** after a grant to 2, hold req1 and req3 continuously valid → next grants are 3, 1, 3, 1. No `req_ready` appears during WAIT/RESP.
5. **F2I path:** operands 0x3F800000, 0x41200000, 0xC2C80000 with op=0 → `resp_data` matches a standalone `Floating_Point_to_Integer` instance bit-for-bit. Mixed op sequence → no cross-selection.
6. **Reset mid-WAIT:** assert reset in WAIT, release, then issue req2 → no stale `resp_valid` bit; grant goes to req2 with `rr_ptr` restarting at 0; `done_count` counts from 0.
